// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PC   = 2'd1,
    OWN_LDST = 2'd2
  } owner_t;

  localparam int RD_LAT_MAX     = 4;
  localparam int STARVE_MAX_DEF = 4;

  // Owner tag pushed into the response pipeline for this cycle's command.
  function automatic owner_t read_owner(input logic rd_gnt, input logic is_ldst);
    owner_t own;
    if (!rd_gnt) begin
      own = OWN_NONE;
    end else if (is_ldst) begin
      own = OWN_LDST;
    end else begin
      own = OWN_PC;
    end
    return own;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep owner-tag shift register; the tag leaving it marks which
// requester owns the read data arriving from memory this cycle.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] tag_i,
  output logic [1:0] tag_o
);

  // Out-of-range latencies are clamped so the array is never empty.
  localparam int DEPTH = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

  owner_t pipe_q [DEPTH];
  owner_t pipe_d [DEPTH];

  // Next-state: shift one stage per cycle, new tag enters at stage 0.
  always_comb begin
    pipe_d[0] = owner_t'(tag_i);
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage registers; clearing drops every in-flight read.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= OWN_NONE;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency RAM between CPU fetch and load/store.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int IW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] i_pc_addr,
  input  logic          i_pc_rd,
  input  logic [3:0]    i_pc_byte_en,
  output logic          o_pc_waitrequest,
  output logic [IW-1:0] o_pc_rddata,
  output logic          o_pc_rddatavalid,
  input  logic [IW-1:0] i_ldst_addr,
  input  logic          i_ldst_rd,
  input  logic          i_ldst_wr,
  input  logic [IW-1:0] i_ldst_wrdata,
  input  logic [3:0]    i_ldst_byte_en,
  output logic          o_ldst_waitrequest,
  output logic [IW-1:0] o_ldst_rddata,
  output logic          o_ldst_rddatavalid,
  output logic [IW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [IW-1:0] o_mem_wrdata,
  output logic [3:0]    o_mem_byte_en,
  input  logic [IW-1:0] i_mem_rddata
);

  logic   pc_req_s;
  logic   ls_req_s;
  logic   force_pc_s;
  logic   gnt_pc_s;
  logic   gnt_ls_s;
  owner_t tag_in_s;
  logic [1:0] tag_out_s;

  assign pc_req_s = i_pc_rd;
  assign ls_req_s = i_ldst_rd | i_ldst_wr;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 2);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;

  assign force_pc_s = (starve_q == STARVE_LIM);

  // Count consecutive load/store wins over a pending fetch, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!i_pc_rd || gnt_pc_s) begin
      starve_d = {CW{1'b0}};
    end else if (gnt_ls_s && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= {CW{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  localparam int STARVE_MAX_UNUSED = STARVE_MAX;
  assign force_pc_s = 1'b0;
`endif

  // Grant: load/store wins conflicts unless the fetch is being forced through.
  always_comb begin
    gnt_pc_s = 1'b0;
    gnt_ls_s = 1'b0;
    if (!reset) begin
      gnt_pc_s = 1'b0;
      gnt_ls_s = 1'b0;
    end else if (ls_req_s && !(pc_req_s && force_pc_s)) begin
      gnt_ls_s = 1'b1;
    end else if (pc_req_s) begin
      gnt_pc_s = 1'b1;
    end else begin
      gnt_pc_s = 1'b0;
      gnt_ls_s = 1'b0;
    end
  end

  // Memory command mux; idle cycles present the fetch fields.
  always_comb begin
    o_mem_addr    = i_pc_addr;
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    o_mem_wrdata  = {IW{1'b0}};
    o_mem_byte_en = i_pc_byte_en;
    if (gnt_ls_s) begin
      o_mem_addr    = i_ldst_addr;
      o_mem_rd      = i_ldst_rd & ~i_ldst_wr;
      o_mem_wr      = i_ldst_wr;
      o_mem_wrdata  = i_ldst_wrdata;
      o_mem_byte_en = i_ldst_byte_en;
    end else if (gnt_pc_s) begin
      o_mem_rd      = 1'b1;
    end else begin
      o_mem_rd      = 1'b0;
    end
  end

  assign o_pc_waitrequest   = ~reset | (pc_req_s & ~gnt_pc_s);
  assign o_ldst_waitrequest = ~reset | (ls_req_s & ~gnt_ls_s);

  assign tag_in_s = read_owner(o_mem_rd, gnt_ls_s);

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .clr_n (reset),
    .tag_i (tag_in_s),
    .tag_o (tag_out_s)
  );

  // Response steering from the tag leaving the pipeline.
  always_comb begin
    o_pc_rddatavalid   = 1'b0;
    o_ldst_rddatavalid = 1'b0;
    case (owner_t'(tag_out_s))
      OWN_PC:   o_pc_rddatavalid   = 1'b1;
      OWN_LDST: o_ldst_rddatavalid = 1'b1;
      OWN_NONE: o_pc_rddatavalid   = 1'b0;
      default:  o_pc_rddatavalid   = 1'b0;
    endcase
  end

  assign o_pc_rddata   = i_mem_rddata;
  assign o_ldst_rddata = i_mem_rddata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port, fixed-latency synchronous memory between the CPU's two memory ports: the read-only instruction fetch port and the read/write load/store port. It lets the pipelined CPU run from a single unified instruction/data RAM. It sits between the `cpu` ports and the RAM:
- It grants at most one command per cycle.
- It stalls the losing requester with a wait-request.
- It routes each read response back to the requester that issued it, using an in-flight owner-tag pipeline.

## Interface
Parameters:
- `IW`, default 32: data and address width.
- `RD_LAT`, default 1: memory read latency in cycles, legal range 1..4.
- `STARVE_MAX`, default 4: maximum number of consecutive load/store grants while a fetch is pending. Used only when the starvation guard is compiled in.

Ports:
- `clk`  input  1  clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `i_pc_addr`  input  IW  fetch address.
- `i_pc_rd`  input  1  fetch read request.
- `i_pc_byte_en`  input  4  fetch byte enables.
- `o_pc_waitrequest`  output  1  fetch not granted this cycle; the requester must hold its request.
- `o_pc_rddata`  output  IW  fetch read data.
- `o_pc_rddatavalid`  output  1  `o_pc_rddata` is valid this cycle.
- `i_ldst_addr`  input  IW  load/store address.
- `i_ldst_rd`  input  1  load request.
- `i_ldst_wr`  input  1  store request.
- `i_ldst_wrdata`  input  IW  store data.
- `i_ldst_byte_en`  input  4  load/store byte enables.
- `o_ldst_waitrequest`  output  1  load/store not granted this cycle.
- `o_ldst_rddata`  output  IW  load data.
- `o_ldst_rddatavalid`  output  1  `o_ldst_rddata` is valid this cycle.
- `o_mem_addr`, `o_mem_rd`, `o_mem_wr`, `o_mem_wrdata`, `o_mem_byte_en`  output  IW/1/1/IW/4  memory command.
- `i_mem_rddata`  input  IW  memory read data, valid exactly `RD_LAT` cycles after a read command.

## Operation
- **Requests.** A fetch request is `i_pc_rd`. A load/store request is `i_ldst_rd | i_ldst_wr`.
- **Store/load conflict.** If `i_ldst_wr` and `i_ldst_rd` are both high, the cycle is a write and the read is ignored.
- **Grant is combinational within the cycle.** The granted requester's fields drive `o_mem_*` in the same cycle, and its waitrequest is 0.
- **Losing requester.** Its waitrequest is 1. It must hold address, data and byte enables stable until granted.
- **No request.** `o_mem_rd` = `o_mem_wr` = 0. Both waitrequests are 0. `o_mem_addr`, `o_mem_wrdata` and `o_mem_byte_en` hold the fetch fields.
- **Priority.** Load/store wins a conflict, because it is the older instruction.
- **Starvation counter (`starve_cnt`).**
  - Increments on each conflict cycle in which load/store is granted.
  - Clears whenever fetch is granted or `i_pc_rd` is 0.
  - When `starve_cnt` equals `STARVE_MAX`, the next conflict grants fetch.
- **Owner tag pipeline.** Every granted read pushes an owner tag (`OWN_PC` or `OWN_LDST`) into an `RD_LAT`-deep shift register. Cycles without a granted read push `OWN_NONE`. Writes push `OWN_NONE`.
- **Read response routing.** The tag leaving the pipeline selects which `*_rddatavalid` is asserted. `i_mem_rddata` is passed to both `*_rddata` outputs.
- **Ordering.** Responses return in issue order. Back-to-back reads sustain one read per cycle.

## Timing
- **Reset values** (while `reset` = 0):
  - `o_mem_rd` = `o_mem_wr` = 0.
  - Both waitrequests = 1.
  - Both rddatavalids = 0.
  - Tag pipeline is all `OWN_NONE`; `starve_cnt` = 0.
- **Read latency.** A read granted in cycle N returns its valid in cycle N+`RD_LAT`.
- **Write** completes in the grant cycle. There is no response.
- **Reset mid-operation.** All in-flight reads are dropped. No rddatavalid is asserted after reset is released until a new read has been granted.
- **Counter wrap.** `starve_cnt` saturates at `STARVE_MAX` and never wraps.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- **Defined:** the starvation counter exists and fetch is forced through after `STARVE_MAX` consecutive load/store grants.
- **Undefined:** strict load/store priority. There is no counter, and `STARVE_MAX` is unused.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_PC, OWN_LDST} owner_t`.
  - Constants `RD_LAT_MAX` = 4 and `STARVE_MAX_DEF` = 4.
- Sub-module `rd_tag_pipe`: a parameterised `RD_LAT`-deep `owner_t` shift register with asynchronous active-low clear.

## Test plan
Bench settings for all scenarios: `RD_LAT`=2, `STARVE_MAX`=4.
1. Hold `reset`=0 with both ports requesting → `o_mem_rd`=`o_mem_wr`=0, both waitrequests=1, no valids.
2. Fetch-only read of addr 0x10 in cycle N, memory returns 0x00000013 → `o_mem_rd`=1 with `o_mem_addr`=0x10 in cycle N, `o_pc_waitrequest`=0; `o_pc_rddatavalid`=1 with data 0x00000013 in cycle N+2.
3. Fetch read of 0x20 and load of 0x80 both requested in cycle N → load granted in N with `o_pc_waitrequest`=1; fetch granted in N+1; `o_ldst_rddatavalid` in N+2, `o_pc_rddatavalid` in N+3.
4. Loads requested for 6 consecutive cycles while fetch is pending → with the macro defined, fetch is granted in cycle 5; without it, fetch is granted in cycle 7.
5. Store of 0xDEADBEEF to 0x40 with byte enables 0011, alongside a fetch → `o_mem_wr`=1 and `o_mem_byte_en`=0011 in the grant cycle; fetch granted next cycle; no `o_ldst_rddatavalid` ever.
6. Two reads in flight, then `reset` pulsed low for 1 cycle → no rddatavalid is asserted after release.
